// File: rtl/bus_cycle_sequencer.sv
// Bus-cycle timing generator: address phases, M1/M2 opcode fetch, execute phases,
// with ROM/RAM command strobes and an end-of-cycle stall.
module bus_cycle_sequencer #(
   parameter  int unsigned DATA_W    = 4,
   parameter  int unsigned ADDR_W    = 12,
   parameter  int unsigned X_CYCLES  = 3,
   parameter  int unsigned NUM_BANKS = 4,
   localparam int unsigned K         = ADDR_W / DATA_W,
   localparam int unsigned N         = K + 2 + X_CYCLES,
   localparam int unsigned CW        = $clog2(N),
   localparam int unsigned BW        = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  stall,
   input  logic [ADDR_W-1:0]     pc,
   input  logic [DATA_W-1:0]     data_in,
   output logic [DATA_W-1:0]     data_out,
   output logic                  data_oe,
   output logic [CW-1:0]         cycle,
   output logic                  sync,
   output logic                  rom_cmd,
   output logic [NUM_BANKS-1:0]  ram_cmd,
   input  logic                  bank_we,
   input  logic [BW-1:0]         bank_wdata,
   input  logic                  io_cycle,
   output logic [2*DATA_W-1:0]   opcode,
   output logic                  opcode_valid,
   output logic                  pc_advance
);

   // Reject parameter sets the phase layout cannot represent.
   if ((ADDR_W % DATA_W) != 0 || X_CYCLES < 2 || NUM_BANKS < 1) begin : g_param_check
      $error("bus_cycle_sequencer: illegal parameter combination");
   end

   localparam logic [CW-1:0] CYC_LAST = CW'(N - 1);
   localparam logic [CW-1:0] CYC_AK   = CW'(K - 1);
   localparam logic [CW-1:0] CYC_M1   = CW'(K);
   localparam logic [CW-1:0] CYC_M2   = CW'(K + 1);
   localparam logic [CW-1:0] CYC_X2   = CW'(K + 3);

   logic [CW-1:0]     cycle_nxt;
   logic [ADDR_W-1:0] addr_q;
   logic [BW-1:0]     bank_q;
   logic              strobe;

   // Subcycle counter register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) cycle <= CYC_LAST;
      else        cycle <= cycle_nxt;
   end

   // Next subcycle: wrap at the end of the instruction cycle unless stalled there.
   always_comb begin
      cycle_nxt = cycle + CW'(1);
      if (cycle == CYC_LAST) begin
         cycle_nxt = stall ? CYC_LAST : '0;
      end
   end

   // Capture the fetch address once per instruction cycle, on entry to A1.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)                           addr_q <= '0;
      else if (cycle == CYC_LAST && !stall) addr_q <= pc;
   end

   // Bank select register; takes effect from the following clock.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)       bank_q <= '0;
      else if (bank_we) bank_q <= bank_wdata;
   end

   // Opcode assembly from M1 (high word) and M2 (low word); valid pulses in X1.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         opcode       <= '0;
         opcode_valid <= 1'b0;
      end else begin
         opcode_valid <= (cycle == CYC_M2);
         if (cycle == CYC_M1)      opcode[2*DATA_W-1:DATA_W] <= data_in;
         else if (cycle == CYC_M2) opcode[DATA_W-1:0]        <= data_in;
      end
   end

   // Address word mux, least significant word in A1.
   always_comb begin
      data_out = '0;
      for (int unsigned i = 0; i < K; i++) begin
         if (cycle == CW'(i)) data_out = addr_q[DATA_W*i +: DATA_W];
      end
   end

   assign data_oe    = (cycle < CW'(K));
   assign sync       = (cycle == CYC_LAST);
   assign pc_advance = (cycle == CYC_M1);
   assign strobe     = (cycle == CYC_AK) || (io_cycle && cycle == CYC_X2);
   assign rom_cmd    = ~strobe;

   // One-hot active-low bank strobe; an out-of-range bank selects no line.
   always_comb begin
      ram_cmd = '1;
      for (int unsigned b = 0; b < NUM_BANKS; b++) begin
         if (strobe && bank_q == BW'(b)) ram_cmd[b] = 1'b0;
      end
   end

endmodule

// File: tb/tb_bus_cycle_sequencer.sv
// Self-checking bench for bus_cycle_sequencer: directed table, reset corner case,
// randomized run against a reference model, and a second parameter set.
module tb_bus_cycle_sequencer;

   localparam int unsigned DW = 4, AW = 12, XC = 3, NB = 4;
   localparam int unsigned K = AW / DW, N = K + 2 + XC;
   localparam int unsigned K2 = 2, N2 = 6;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        stall, bank_we, io_cycle;
   logic [11:0] pc;
   logic [3:0]  data_in, data_out, ram_cmd;
   logic [1:0]  bank_wdata;
   logic [2:0]  cycle;
   logic        data_oe, sync, rom_cmd, opcode_valid, pc_advance;
   logic [7:0]  opcode;

   logic [15:0] b_pc = 16'hBEEF;
   logic [7:0]  b_data_in = 8'h00, b_data_out;
   logic [0:0]  b_bank_wdata = 1'b0;
   logic        b_stall = 1'b0, b_bank_we = 1'b0, b_io_cycle = 1'b0;
   logic [2:0]  b_cycle;
   logic        b_data_oe, b_sync, b_rom_cmd, b_opcode_valid, b_pc_advance;
   logic [1:0]  b_ram_cmd;
   logic [15:0] b_opcode;

   int errors = 0;
   int checks = 0;

   // Reference model state
   int unsigned m_cyc, m_addr, m_bank, m_op;
   bit          m_vld;

   always #5 clock = ~clock;

   bus_cycle_sequencer #(.DATA_W(4), .ADDR_W(12), .X_CYCLES(3), .NUM_BANKS(4)) dut (
      .clock(clock), .reset(reset), .stall(stall), .pc(pc), .data_in(data_in),
      .data_out(data_out), .data_oe(data_oe), .cycle(cycle), .sync(sync),
      .rom_cmd(rom_cmd), .ram_cmd(ram_cmd), .bank_we(bank_we), .bank_wdata(bank_wdata),
      .io_cycle(io_cycle), .opcode(opcode), .opcode_valid(opcode_valid),
      .pc_advance(pc_advance));

   bus_cycle_sequencer #(.DATA_W(8), .ADDR_W(16), .X_CYCLES(2), .NUM_BANKS(2)) dut2 (
      .clock(clock), .reset(reset), .stall(b_stall), .pc(b_pc), .data_in(b_data_in),
      .data_out(b_data_out), .data_oe(b_data_oe), .cycle(b_cycle), .sync(b_sync),
      .rom_cmd(b_rom_cmd), .ram_cmd(b_ram_cmd), .bank_we(b_bank_we),
      .bank_wdata(b_bank_wdata), .io_cycle(b_io_cycle), .opcode(b_opcode),
      .opcode_valid(b_opcode_valid), .pc_advance(b_pc_advance));

   typedef struct {
      logic        stall;
      logic [11:0] pc;
      logic [3:0]  din;
      logic        we;
      logic [1:0]  wd;
      logic        io;
      logic [2:0]  cyc;
      logic        oe;
      logic [3:0]  dout;
      logic        rom;
      logic [3:0]  ram;
      logic        sync;
      logic        adv;
      logic [7:0]  op;
      logic        vld;
   } vec_t;

   vec_t tbl [23];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_cyc = N - 1; m_addr = 0; m_bank = 0; m_op = 0; m_vld = 1'b0;
   endtask

   // One clock of the instruction-cycle rules, using the inputs held across the edge.
   task automatic model_step();
      if (m_cyc == K)          m_op = (m_op & 32'h0F) | (32'(data_in) << DW);
      else if (m_cyc == K + 1) m_op = (m_op & 32'hF0) | 32'(data_in);
      m_vld = (m_cyc == K + 1);
      if (bank_we) m_bank = 32'(bank_wdata);
      if (m_cyc == N - 1) begin
         if (!stall) begin
            m_cyc  = 0;
            m_addr = 32'(pc);
         end
      end else begin
         m_cyc = m_cyc + 1;
      end
   endtask

   task automatic tick();
      @(posedge clock);
      if (reset) model_step();
      #1;
   endtask

   task automatic cmp_model(input string tag);
      bit         strobe;
      logic [3:0] e_ram;
      strobe = (m_cyc == K - 1) || (m_cyc == K + 3 && io_cycle);
      e_ram  = 4'hF;
      if (strobe && m_bank < NB) e_ram = 4'hF & ~(4'b0001 << m_bank);
      check({tag, ".cycle"},   32'(cycle),   m_cyc);
      check({tag, ".data_oe"}, 32'(data_oe), 32'(m_cyc < K));
      if (m_cyc < K) check({tag, ".data_out"}, 32'(data_out), (m_addr >> (DW * m_cyc)) & 32'hF);
      check({tag, ".sync"},         32'(sync),         32'(m_cyc == N - 1));
      check({tag, ".pc_advance"},   32'(pc_advance),   32'(m_cyc == K));
      check({tag, ".rom_cmd"},      32'(rom_cmd),      32'(!strobe));
      check({tag, ".ram_cmd"},      32'(ram_cmd),      32'(e_ram));
      check({tag, ".opcode"},       32'(opcode),       m_op);
      check({tag, ".opcode_valid"}, 32'(opcode_valid), 32'(m_vld));
   endtask

   task automatic cmp_dut2(input int unsigned idx);
      int unsigned c;
      c = (idx == 0) ? N2 - 1 : (idx - 1) % N2;
      check($sformatf("p2[%0d].cycle", idx),   32'(b_cycle),   c);
      check($sformatf("p2[%0d].data_oe", idx), 32'(b_data_oe), 32'(c < K2));
      if (c == 0) check($sformatf("p2[%0d].data_out", idx), 32'(b_data_out), 32'hEF);
      if (c == 1) check($sformatf("p2[%0d].data_out", idx), 32'(b_data_out), 32'hBE);
      check($sformatf("p2[%0d].rom_cmd", idx), 32'(b_rom_cmd), 32'(c != K2 - 1));
      check($sformatf("p2[%0d].ram_cmd", idx), 32'(b_ram_cmd), (c == K2 - 1) ? 32'h2 : 32'h3);
      check($sformatf("p2[%0d].sync", idx),    32'(b_sync),    32'(c == N2 - 1));
   endtask

   initial begin
      int vpulses;

      //          stall pc       din   we    wd    io  | cyc   oe    dout  rom   ram    sync  adv   op     vld
      tbl[0]  = '{1'b0, 12'hABC, 4'h0, 1'b0, 2'd0, 1'b0, 3'd7, 1'b0, 4'h0, 1'b1, 4'hF, 1'b1, 1'b0, 8'h00, 1'b0};
      tbl[1]  = '{1'b0, 12'hABC, 4'h0, 1'b0, 2'd0, 1'b0, 3'd0, 1'b1, 4'hC, 1'b1, 4'hF, 1'b0, 1'b0, 8'h00, 1'b0};
      tbl[2]  = '{1'b0, 12'hABC, 4'h0, 1'b0, 2'd0, 1'b0, 3'd1, 1'b1, 4'hB, 1'b1, 4'hF, 1'b0, 1'b0, 8'h00, 1'b0};
      tbl[3]  = '{1'b0, 12'hABC, 4'h0, 1'b0, 2'd0, 1'b0, 3'd2, 1'b1, 4'hA, 1'b0, 4'hE, 1'b0, 1'b0, 8'h00, 1'b0};
      tbl[4]  = '{1'b0, 12'hABC, 4'h2, 1'b1, 2'd2, 1'b0, 3'd3, 1'b0, 4'h0, 1'b1, 4'hF, 1'b0, 1'b1, 8'h00, 1'b0};
      tbl[5]  = '{1'b0, 12'hABC, 4'h5, 1'b0, 2'd0, 1'b0, 3'd4, 1'b0, 4'h0, 1'b1, 4'hF, 1'b0, 1'b0, 8'h20, 1'b0};
      tbl[6]  = '{1'b0, 12'hABC, 4'h0, 1'b0, 2'd0, 1'b0, 3'd5, 1'b0, 4'h0, 1'b1, 4'hF, 1'b0, 1'b0, 8'h25, 1'b1};
      tbl[7]  = '{1'b0, 12'hABC, 4'h0, 1'b0, 2'd0, 1'b1, 3'd6, 1'b0, 4'h0, 1'b0, 4'hB, 1'b0, 1'b0, 8'h25, 1'b0};
      tbl[8]  = '{1'b0, 12'h456, 4'h0, 1'b0, 2'd0, 1'b1, 3'd7, 1'b0, 4'h0, 1'b1, 4'hF, 1'b1, 1'b0, 8'h25, 1'b0};
      tbl[9]  = '{1'b0, 12'hABC, 4'h0, 1'b0, 2'd0, 1'b0, 3'd0, 1'b1, 4'h6, 1'b1, 4'hF, 1'b0, 1'b0, 8'h25, 1'b0};
      tbl[10] = '{1'b0, 12'hABC, 4'h0, 1'b0, 2'd0, 1'b0, 3'd1, 1'b1, 4'h5, 1'b1, 4'hF, 1'b0, 1'b0, 8'h25, 1'b0};
      tbl[11] = '{1'b0, 12'hABC, 4'h0, 1'b1, 2'd3, 1'b0, 3'd2, 1'b1, 4'h4, 1'b0, 4'hB, 1'b0, 1'b0, 8'h25, 1'b0};
      tbl[12] = '{1'b0, 12'hABC, 4'h9, 1'b0, 2'd0, 1'b0, 3'd3, 1'b0, 4'h0, 1'b1, 4'hF, 1'b0, 1'b1, 8'h25, 1'b0};
      tbl[13] = '{1'b0, 12'hABC, 4'hE, 1'b0, 2'd0, 1'b0, 3'd4, 1'b0, 4'h0, 1'b1, 4'hF, 1'b0, 1'b0, 8'h95, 1'b0};
      tbl[14] = '{1'b0, 12'hABC, 4'h0, 1'b0, 2'd0, 1'b0, 3'd5, 1'b0, 4'h0, 1'b1, 4'hF, 1'b0, 1'b0, 8'h9E, 1'b1};
      tbl[15] = '{1'b0, 12'hABC, 4'h0, 1'b0, 2'd0, 1'b1, 3'd6, 1'b0, 4'h0, 1'b0, 4'h7, 1'b0, 1'b0, 8'h9E, 1'b0};
      tbl[16] = '{1'b1, 12'h777, 4'h0, 1'b0, 2'd0, 1'b0, 3'd7, 1'b0, 4'h0, 1'b1, 4'hF, 1'b1, 1'b0, 8'h9E, 1'b0};
      tbl[17] = '{1'b1, 12'h123, 4'h0, 1'b0, 2'd0, 1'b0, 3'd7, 1'b0, 4'h0, 1'b1, 4'hF, 1'b1, 1'b0, 8'h9E, 1'b0};
      tbl[18] = '{1'b1, 12'h123, 4'h0, 1'b0, 2'd0, 1'b0, 3'd7, 1'b0, 4'h0, 1'b1, 4'hF, 1'b1, 1'b0, 8'h9E, 1'b0};
      tbl[19] = '{1'b0, 12'h123, 4'h0, 1'b0, 2'd0, 1'b0, 3'd7, 1'b0, 4'h0, 1'b1, 4'hF, 1'b1, 1'b0, 8'h9E, 1'b0};
      tbl[20] = '{1'b0, 12'h000, 4'h0, 1'b0, 2'd0, 1'b0, 3'd0, 1'b1, 4'h3, 1'b1, 4'hF, 1'b0, 1'b0, 8'h9E, 1'b0};
      tbl[21] = '{1'b0, 12'h000, 4'h0, 1'b0, 2'd0, 1'b0, 3'd1, 1'b1, 4'h2, 1'b1, 4'hF, 1'b0, 1'b0, 8'h9E, 1'b0};
      tbl[22] = '{1'b0, 12'h000, 4'h0, 1'b0, 2'd0, 1'b0, 3'd2, 1'b1, 4'h1, 1'b0, 4'h7, 1'b0, 1'b0, 8'h9E, 1'b0};

      stall = 1'b0; pc = 12'h000; data_in = 4'h0; bank_we = 1'b0; bank_wdata = 2'd0; io_cycle = 1'b0;
      model_reset();

      // Reset state while held
      #1 reset = 1'b0;
      #1 cmp_model("reset");
      tick(); cmp_model("reset_hold");
      tick();

      // Directed table; the second parameter set runs alongside from the same release
      reset = 1'b1;
      for (int i = 0; i < 23; i++) begin
         stall = tbl[i].stall; pc = tbl[i].pc; data_in = tbl[i].din;
         bank_we = tbl[i].we; bank_wdata = tbl[i].wd; io_cycle = tbl[i].io;
         #1;
         check($sformatf("row%0d.cycle", i),        32'(cycle),        32'(tbl[i].cyc));
         check($sformatf("row%0d.data_oe", i),      32'(data_oe),      32'(tbl[i].oe));
         if (tbl[i].oe) check($sformatf("row%0d.data_out", i), 32'(data_out), 32'(tbl[i].dout));
         check($sformatf("row%0d.rom_cmd", i),      32'(rom_cmd),      32'(tbl[i].rom));
         check($sformatf("row%0d.ram_cmd", i),      32'(ram_cmd),      32'(tbl[i].ram));
         check($sformatf("row%0d.sync", i),         32'(sync),         32'(tbl[i].sync));
         check($sformatf("row%0d.pc_advance", i),   32'(pc_advance),   32'(tbl[i].adv));
         check($sformatf("row%0d.opcode", i),       32'(opcode),       32'(tbl[i].op));
         check($sformatf("row%0d.opcode_valid", i), 32'(opcode_valid), 32'(tbl[i].vld));
         cmp_dut2(i);
         tick();
      end

      // Reset asserted in M2 with a half-fetched opcode
      bank_we = 1'b0; stall = 1'b0; io_cycle = 1'b0;
      data_in = 4'hF;
      #1 cmp_model("pre_m1");
      tick();
      data_in = 4'h3;
      #1 cmp_model("in_m2");
      reset = 1'b0;
      model_reset();
      #1;
      check("mid_reset.data_oe", 32'(data_oe), 32'h0);
      check("mid_reset.cycle",   32'(cycle),   32'h7);
      check("mid_reset.sync",    32'(sync),    32'h1);
      check("mid_reset.opcode",  32'(opcode),  32'h0);
      tick();
      reset = 1'b1;
      vpulses = 0;
      for (int i = 0; i < 8; i++) begin
         data_in = 4'(i + 6);
         #1;
         if (i < 6 && opcode_valid) vpulses++;
         cmp_model($sformatf("post_reset%0d", i));
         tick();
      end
      check("post_reset.early_valid", 32'(vpulses), 32'h0);

      // Randomized run with occasional asynchronous resets
      for (int i = 0; i < 800; i++) begin
         stall      = ($urandom_range(0, 2) == 0);
         pc         = 12'($urandom);
         data_in    = 4'($urandom);
         bank_we    = ($urandom_range(0, 3) == 0);
         bank_wdata = 2'($urandom);
         io_cycle   = 1'($urandom);
         if ($urandom_range(0, 99) == 0) begin
            reset = 1'b0;
            model_reset();
            #1 cmp_model($sformatf("rnd_rst%0d", i));
            tick();
            reset = 1'b1;
         end else begin
            #1 cmp_model($sformatf("rnd%0d", i));
            tick();
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
